fetch_decode_frontend: RTL and testbench
========================================

# fetch_decode_frontend

Parametrised IF stage plus IF/ID pipeline register for the MIPS pipeline, replacing the fixed 32-bit fetch/decode glue. It owns the PC and the IF/ID register, and resolves `beq`/`bne`/`j` in ID. It detects load-use and branch-operand hazards, applies bubbles and flushes, and handshakes with an instruction memory that may not answer every cycle. Saturating stall/flush counters support CPI measurement in simulation.

## Interface
- `XLEN`, 32: datapath/PC width; legal values are 32 or 64.
- `CTRL_W`, 11: width of the control bundle from the control unit.
- `RESET_PC`, 0: PC value loaded on reset.
- `CNT_W`, 16: width of the performance counters.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  XLEN  fetch address; equals `pc`.
- `imem_rdata`  in  32  instruction at `imem_addr`; combinational.
- `imem_ready`  in  1  `imem_rdata` is valid this cycle.
- `ext_flush`  in  1  kill the IF/ID contents, e.g. on an exception.
- `ctrl_in`  in  CTRL_W  control unit output for `id_inst`.
- `rs_data`, `rt_data`  in  XLEN  register file read data for `id_inst[25:21]` and `id_inst[20:16]`.
- `idex_mem_read`, `idex_reg_write`  in  1  ID/EX stage control bits.
- `idex_rt`, `idex_rd`  in  5  ID/EX load target and post-RegDst destination.
- `exmem_mem_read`  in  1  EX/MEM is a load.
- `exmem_rd`  in  5  EX/MEM destination register.
- `id_inst`  out  32  IF/ID instruction.
- `id_pc_plus4`  out  XLEN  IF/ID PC+4.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `id_ctrl`  out  CTRL_W  `ctrl_in`, or 0 when bubbling.
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating event counters.

## Operation
- **Decode of `id_inst`:**
  - opcode = `[31:26]`; `beq`=4, `bne`=5, `j`=2.
  - imm = sign-extend of `[15:0]` to XLEN.
- **Load-use hazard:** `idex_mem_read` & `idex_rt`≠0 & (`idex_rt`==rs | `idex_rt`==rt).
- **Branch hazard:** ID holds `beq`/`bne` and either of:
  - `idex_reg_write` & `idex_rd`≠0 & `idex_rd`∈{rs,rt};
  - `exmem_mem_read` & `exmem_rd`≠0 & `exmem_rd`∈{rs,rt}.
- **stall** = `id_valid` & (load-use | branch hazard).
- **taken** = `id_valid` & !stall & one of:
  - `beq` & `rs_data`==`rt_data`;
  - `bne` & `rs_data`≠`rt_data`;
  - `j`.
- **Targets:**
  - Branch target = `id_pc_plus4` + (imm<<2), mod 2^XLEN.
  - Jump target = {`id_pc_plus4[XLEN-1:28]`, `id_inst[25:0]`, 2'b00}.
- **`id_ctrl`** = (stall | !`id_valid`) ? 0 : `ctrl_in`.
- **Per-cycle update, first matching rule wins:**
  1. `rst`: `pc`=RESET_PC, `id_inst`=0, `id_pc_plus4`=0, `id_valid`=0, both counters 0.
  2. stall: `pc` and IF/ID hold; `stall_cnt`+1. `ext_flush` is ignored this cycle.
  3. `ext_flush`: IF/ID←bubble (`id_valid`=0, `id_inst`=0); `pc`←`pc`+4 if `imem_ready`, else hold; `flush_cnt`+1.
  4. taken: `pc`←target; IF/ID←bubble; `flush_cnt`+1.
  5. !`imem_ready`: `pc` holds; IF/ID←bubble.
  6. Normal: `pc`←`pc`+4; `id_inst`←`imem_rdata`; `id_pc_plus4`←`pc`+4; `id_valid`=1.
- **Counters:** saturate at 2^CNT_W−1 and never wrap.

## Timing
- Fetch is single-cycle, combinational from `pc` to `imem_rdata`.
- Instruction fetched in cycle N appears on `id_inst` in cycle N+1.
- Taken branch/jump:
  - resolved in ID, one-cycle penalty;
  - target instruction fetched in the cycle after resolution;
  - reaches ID two cycles after the branch entered ID.
- Load-use: exactly one stall cycle.
- Branch on a preceding ALU result: one stall cycle. Branch on a load result: two stall cycles.
- All outputs change only on `clk` rising edge or asynchronously on `rst`, except the combinational outputs `id_ctrl` and `imem_addr`.
- Reset mid-stall or mid-redirect: all state returns to reset values immediately. The first fetch is from RESET_PC after `rst` falls.

## Test plan
- **Straight-line fetch:** reset, `imem_ready`=1, memory holds 4 `add`s.
  - `imem_addr` = 0,4,8,12.
  - `id_valid`=1 from cycle 2 onward.
  - `id_pc_plus4` = 4,8,12,16.
- **Taken beq:** `beq` at 0x8 with imm=3 and `rs_data`==`rt_data`.
  - Next `pc`=0x18.
  - Following ID cycle has `id_valid`=0 and `id_ctrl`=0.
  - `flush_cnt`=1.
  - Repeat with `bne` and equal operands → not taken; `pc` proceeds to 0x10.
- **Jump with XLEN=64:** `id_pc_plus4`=0x0000_0001_4000_0010, `j` target field 0x0000100 → `pc`=0x0000_0001_4000_0400.
- **Load-use:** `idex_mem_read`=1, `idex_rt`=5, ID instruction reads rs=5.
  - One cycle: `pc` and `id_inst` held, `id_ctrl`=0, `stall_cnt`=1.
  - Repeat with `idex_rt`=0 → no stall.
- **Memory wait plus simultaneous events:**
  - `imem_ready` low for 3 cycles → `pc` constant, 3 bubbles in ID.
  - `ext_flush` asserted during a stall → ignored.
  - Taken branch with `imem_ready`=0 → redirect still happens.
- **Saturation and reset:** CNT_W=2 with 5 consecutive stalls → `stall_cnt`=3. Assert `rst` mid-stall → all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/fetch_decode_frontend_if.sv
// ---------------------------------------------------------------------------
// fetch_decode_frontend_if
//
// Instruction-memory fetch bus between the fetch/decode front end and the
// instruction memory. The memory answers combinationally from the address.
// When it cannot answer in the current cycle it drops `ready`.
//
// Signals:
//   addr   fetch address (front end -> memory), equals the current PC
//   rdata  32-bit instruction at `addr` (memory -> front end)
//   ready  `rdata` is valid this cycle (memory -> front end)
//
// Modports:
//   master  front-end side (drives addr)
//   slave   memory side (drives rdata, ready)
// ---------------------------------------------------------------------------
interface fetch_decode_frontend_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] addr;
    logic [31:0]     rdata;
    logic            ready;

    modport master (
        output addr,
        input  rdata,
        input  ready
    );

    modport slave (
        input  addr,
        output rdata,
        output ready
    );
endinterface

// File: rtl/fetch_decode_frontend.sv
// ---------------------------------------------------------------------------
// fetch_decode_frontend
//
// IF stage plus IF/ID pipeline register for a MIPS-style pipeline. The
// module does the following:
//   - Owns the PC.
//   - Fetches over an instruction bus that may stall.
//   - Holds the fetched instruction in IF/ID.
//   - Resolves beq/bne/j in ID.
//   - Detects load-use hazards and branch-operand hazards. It stalls on
//     them, and it flushes on taken control flow and external kills.
//   - Keeps two saturating counters (stall cycles, flush events) for CPI
//     measurement.
//
// Parameters:
//   XLEN      datapath / PC width (32 or 64)
//   CTRL_W    width of the control bundle from the control unit
//   RESET_PC  PC value loaded on reset
//   CNT_W     width of the performance counters
//
// Ports:
//   clk               clock, rising edge
//   rst               asynchronous active-high reset
//   io_imem           instruction bus (master side): addr out, rdata/ready in
//   i_ext_flush       kill IF/ID contents (e.g. exception)
//   i_ctrl_in         control unit output for o_id_inst
//   i_rs_data         register file data for o_id_inst[25:21]
//   i_rt_data         register file data for o_id_inst[20:16]
//   i_idex_mem_read   ID/EX holds a load
//   i_idex_reg_write  ID/EX writes a register
//   i_idex_rt         ID/EX load target register
//   i_idex_rd         ID/EX destination register (after RegDst)
//   i_exmem_mem_read  EX/MEM holds a load
//   i_exmem_rd        EX/MEM destination register
//   o_id_inst         IF/ID instruction
//   o_id_pc_plus4     IF/ID PC+4
//   o_id_valid        IF/ID holds a real instruction
//   o_id_ctrl         i_ctrl_in, or zero when ID is bubbling (combinational)
//   o_stall_cnt       saturating count of stall cycles
//   o_flush_cnt       saturating count of flush events
// ---------------------------------------------------------------------------
module fetch_decode_frontend #(
    parameter int              XLEN     = 32,
    parameter int              CTRL_W   = 11,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    fetch_decode_frontend_if.master io_imem,

    input  logic                  i_ext_flush,
    input  logic [CTRL_W-1:0]     i_ctrl_in,
    input  logic [XLEN-1:0]       i_rs_data,
    input  logic [XLEN-1:0]       i_rt_data,
    input  logic                  i_idex_mem_read,
    input  logic                  i_idex_reg_write,
    input  logic [4:0]            i_idex_rt,
    input  logic [4:0]            i_idex_rd,
    input  logic                  i_exmem_mem_read,
    input  logic [4:0]            i_exmem_rd,

    output logic [31:0]           o_id_inst,
    output logic [XLEN-1:0]       o_id_pc_plus4,
    output logic                  o_id_valid,
    output logic [CTRL_W-1:0]     o_id_ctrl,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt
);

    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;

    // Counter slots: index 0 counts stall cycles, index 1 counts flush events.
    localparam int N_CNT   = 2;
    localparam int CNT_STL = 0;
    localparam int CNT_FLS = 1;

    // -----------------------------------------------------------------------
    // Architectural state
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_id_inst;
    logic [XLEN-1:0] r_id_pc_plus4;
    logic            r_id_valid;

    // -----------------------------------------------------------------------
    // Decode of the IF/ID instruction
    // -----------------------------------------------------------------------
    logic [5:0]      w_opcode;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic            w_is_beq;
    logic            w_is_bne;
    logic            w_is_j;
    logic            w_is_branch;
    logic [XLEN-1:0] w_imm;

    assign w_opcode    = r_id_inst[31:26];
    assign w_rs        = r_id_inst[25:21];
    assign w_rt        = r_id_inst[20:16];
    assign w_is_beq    = (w_opcode == OP_BEQ);
    assign w_is_bne    = (w_opcode == OP_BNE);
    assign w_is_j      = (w_opcode == OP_J);
    assign w_is_branch = w_is_beq | w_is_bne;
    assign w_imm       = {{(XLEN-16){r_id_inst[15]}}, r_id_inst[15:0]};

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    logic w_load_use;
    logic w_br_hz_alu;
    logic w_br_hz_load;
    logic w_stall;

    // Register $0 is hard-wired to zero, so it never creates a dependency.
    assign w_load_use   = i_idex_mem_read && (i_idex_rt != 5'd0) &&
                          ((i_idex_rt == w_rs) || (i_idex_rt == w_rt));

    // Branches compare in ID, so they need operands one stage earlier than
    // the ALU does. An ALU producer still in EX costs one stall cycle. A load
    // costs two cycles: first while it is in EX (caught by w_load_use), then
    // again while it is in MEM.
    assign w_br_hz_alu  = i_idex_reg_write && (i_idex_rd != 5'd0) &&
                          ((i_idex_rd == w_rs) || (i_idex_rd == w_rt));
    assign w_br_hz_load = i_exmem_mem_read && (i_exmem_rd != 5'd0) &&
                          ((i_exmem_rd == w_rs) || (i_exmem_rd == w_rt));

    assign w_stall = r_id_valid &&
                     (w_load_use || (w_is_branch && (w_br_hz_alu || w_br_hz_load)));

    // -----------------------------------------------------------------------
    // Branch / jump resolution
    // -----------------------------------------------------------------------
    logic            w_operands_eq;
    logic            w_taken;
    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_j_target;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_plus4;

    assign w_operands_eq = (i_rs_data == i_rt_data);

    assign w_taken = r_id_valid && !w_stall &&
                     ((w_is_beq && w_operands_eq) ||
                      (w_is_bne && !w_operands_eq) ||
                      w_is_j);

    assign w_br_target = r_id_pc_plus4 + (w_imm << 2);
    // A jump keeps the upper bits of PC+4, so it stays inside the current
    // 256 MiB region. For XLEN=64 that is bits [63:28].
    assign w_j_target  = {r_id_pc_plus4[XLEN-1:28], r_id_inst[25:0], 2'b00};
    assign w_target    = w_is_j ? w_j_target : w_br_target;
    assign w_pc_plus4  = r_pc + XLEN'(4);

    // -----------------------------------------------------------------------
    // PC and IF/ID register. The branches below are in priority order:
    // stall, external flush, taken redirect, memory wait, normal fetch.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_id_inst     <= '0;
            r_id_pc_plus4 <= '0;
            r_id_valid    <= 1'b0;
        end else if (w_stall) begin
            // Freeze PC and IF/ID. An external flush in the same cycle is
            // dropped, because the stalled instruction must still issue.
            r_pc          <= r_pc;
            r_id_inst     <= r_id_inst;
            r_id_pc_plus4 <= r_id_pc_plus4;
            r_id_valid    <= r_id_valid;
        end else if (i_ext_flush) begin
            r_id_inst  <= '0;
            r_id_valid <= 1'b0;
            // The fetch in flight is discarded. The PC still moves on if the
            // memory answered, so that word is not fetched twice.
            if (io_imem.ready) begin
                r_pc <= w_pc_plus4;
            end
        end else if (w_taken) begin
            // The wrong-path instruction being fetched now is dropped. A
            // redirect does not depend on memory readiness.
            r_pc       <= w_target;
            r_id_inst  <= '0;
            r_id_valid <= 1'b0;
        end else if (!io_imem.ready) begin
            r_id_inst  <= '0;
            r_id_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_plus4;
            r_id_inst     <= io_imem.rdata;
            r_id_pc_plus4 <= w_pc_plus4;
            r_id_valid    <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Saturating performance counters
    // -----------------------------------------------------------------------
    logic [N_CNT-1:0] w_cnt_evt;
    logic [CNT_W-1:0] w_cnt_val [N_CNT];

    // A stall suppresses the external flush, so a flush is only counted on
    // cycles that are not stalled.
    assign w_cnt_evt[CNT_STL] = w_stall;
    assign w_cnt_evt[CNT_FLS] = !w_stall && (i_ext_flush || w_taken);

    genvar gi;
    generate
        for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_cnt_evt[gi] && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign w_cnt_val[gi] = r_cnt;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign io_imem.addr  = r_pc;
    assign o_id_inst     = r_id_inst;
    assign o_id_pc_plus4 = r_id_pc_plus4;
    assign o_id_valid    = r_id_valid;
    // A stalled or empty ID stage must not issue control to EX. It sends
    // an all-zero bundle (a nop) instead.
    assign o_id_ctrl     = (w_stall || !r_id_valid) ? '0 : i_ctrl_in;
    assign o_stall_cnt   = w_cnt_val[CNT_STL];
    assign o_flush_cnt   = w_cnt_val[CNT_FLS];

endmodule

// File: tb/tb_fetch_decode_frontend.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_frontend
//
// Directed bench with two instances sharing one set of control inputs.
//   u32: default parameters, RESET_PC = 0. Covers fetch, branch, hazard,
//        wait and flush scenarios.
//   u64: XLEN = 64, CNT_W = 2, RESET_PC = 0x1_4000_000C. Covers the jump
//        upper-bit concatenation, counter saturation and asynchronous reset.
// Each instance reads instructions from its own small memory, indexed by
// addr[5:2].
// ---------------------------------------------------------------------------
module tb_fetch_decode_frontend;

    localparam logic [63:0] RST_PC64 = 64'h0000_0001_4000_000C;
    localparam logic [10:0] CTRL_VAL = 11'h5A5;

    logic        clk;
    logic        rst;
    logic        ready;
    logic        ext_flush;
    logic [10:0] ctrl_in;
    logic [63:0] rs_data;
    logic [63:0] rt_data;
    logic        idex_mem_read;
    logic        idex_reg_write;
    logic [4:0]  idex_rt;
    logic [4:0]  idex_rd;
    logic        exmem_mem_read;
    logic [4:0]  exmem_rd;

    logic [31:0] mem32 [16];
    logic [31:0] mem64 [16];

    logic [31:0] id_inst32;
    logic [31:0] pc4_32;
    logic        valid32;
    logic [10:0] ctrl32;
    logic [15:0] scnt32;
    logic [15:0] fcnt32;

    logic [31:0] id_inst64;
    logic [63:0] pc4_64;
    logic        valid64;
    logic [10:0] ctrl64;
    logic [1:0]  scnt64;
    logic [1:0]  fcnt64;

    int checks   = 0;
    int failures = 0;

    fetch_decode_frontend_if #(.XLEN(32)) bus32 ();
    fetch_decode_frontend_if #(.XLEN(64)) bus64 ();

    assign bus32.rdata = mem32[bus32.addr[5:2]];
    assign bus32.ready = ready;
    assign bus64.rdata = mem64[bus64.addr[5:2]];
    assign bus64.ready = ready;

    fetch_decode_frontend u32 (
        .clk              (clk),
        .rst              (rst),
        .io_imem          (bus32),
        .i_ext_flush      (ext_flush),
        .i_ctrl_in        (ctrl_in),
        .i_rs_data        (rs_data[31:0]),
        .i_rt_data        (rt_data[31:0]),
        .i_idex_mem_read  (idex_mem_read),
        .i_idex_reg_write (idex_reg_write),
        .i_idex_rt        (idex_rt),
        .i_idex_rd        (idex_rd),
        .i_exmem_mem_read (exmem_mem_read),
        .i_exmem_rd       (exmem_rd),
        .o_id_inst        (id_inst32),
        .o_id_pc_plus4    (pc4_32),
        .o_id_valid       (valid32),
        .o_id_ctrl        (ctrl32),
        .o_stall_cnt      (scnt32),
        .o_flush_cnt      (fcnt32)
    );

    fetch_decode_frontend #(
        .XLEN     (64),
        .CTRL_W   (11),
        .RESET_PC (RST_PC64),
        .CNT_W    (2)
    ) u64 (
        .clk              (clk),
        .rst              (rst),
        .io_imem          (bus64),
        .i_ext_flush      (ext_flush),
        .i_ctrl_in        (ctrl_in),
        .i_rs_data        (rs_data),
        .i_rt_data        (rt_data),
        .i_idex_mem_read  (idex_mem_read),
        .i_idex_reg_write (idex_reg_write),
        .i_idex_rt        (idex_rt),
        .i_idex_rd        (idex_rd),
        .i_exmem_mem_read (exmem_mem_read),
        .i_exmem_rd       (exmem_rd),
        .o_id_inst        (id_inst64),
        .o_id_pc_plus4    (pc4_64),
        .o_id_valid       (valid64),
        .o_id_ctrl        (ctrl64),
        .o_stall_cnt      (scnt64),
        .o_flush_cnt      (fcnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // add rd, rs, $2
    function automatic logic [31:0] mk_add(input logic [4:0] rs, input logic [4:0] rd);
        return {6'd0, rs, 5'd2, rd, 5'd0, 6'h20};
    endfunction

    // beq/bne rs=$1, rt=$2, imm=3
    localparam logic [31:0] BEQ_I = {6'd4, 5'd1, 5'd2, 16'd3};
    localparam logic [31:0] BNE_I = {6'd5, 5'd1, 5'd2, 16'd3};
    localparam logic [31:0] J_I   = {6'd2, 26'h0000100};

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) begin
            mem32[i] = mk_add(5'd1, 5'(i + 3));
            mem64[i] = mk_add(5'd1, 5'(i + 3));
        end
    endtask

    task automatic idle_inputs();
        ready          = 1'b1;
        ext_flush      = 1'b0;
        ctrl_in        = CTRL_VAL;
        rs_data        = 64'd0;
        rt_data        = 64'd0;
        idex_mem_read  = 1'b0;
        idex_reg_write = 1'b0;
        idex_rt        = 5'd0;
        idex_rd        = 5'd0;
        exmem_mem_read = 1'b0;
        exmem_rd       = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a rising edge with rst low.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        checks++; if (bus32.addr !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus32.addr, 32'd0); end
        checks++; if (valid32 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid32); end
        checks++; if (id_inst32 !== 32'd0) begin failures++; $display("FAIL reset_inst got=%h exp=0", id_inst32); end
        checks++; if (pc4_32 !== 32'd0) begin failures++; $display("FAIL reset_pc4 got=%h exp=0", pc4_32); end
        checks++; if (ctrl32 !== 11'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", ctrl32); end
        checks++; if (scnt32 !== 16'd0 || fcnt32 !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", scnt32, fcnt32); end
        checks++; if (bus64.addr !== RST_PC64) begin failures++; $display("FAIL reset_pc64 got=%h exp=%h", bus64.addr, RST_PC64); end
        $display("reset: pc32=%h pc64=%h valid=%b", bus32.addr, bus64.addr, valid32);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_straight_line();
        fill_mem();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus32.addr !== 32'(4 * k)) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", k, bus32.addr, 32'(4 * k)); end
            step();
            checks++; if (valid32 !== 1'b1) begin failures++; $display("FAIL seq_valid%0d got=%b exp=1", k, valid32); end
            checks++; if (pc4_32 !== 32'(4 * k + 4)) begin failures++; $display("FAIL seq_pc4_%0d got=%h exp=%h", k, pc4_32, 32'(4 * k + 4)); end
            checks++; if (id_inst32 !== mem32[k]) begin failures++; $display("FAIL seq_inst%0d got=%h exp=%h", k, id_inst32, mem32[k]); end
            #1;
            checks++; if (ctrl32 !== CTRL_VAL) begin failures++; $display("FAIL seq_ctrl%0d got=%h exp=%h", k, ctrl32, CTRL_VAL); end
            $display("straight: cycle %0d pc4=%h inst=%h", k, pc4_32, id_inst32);
        end
    endtask

    task automatic test_beq_taken();
        fill_mem();
        mem32[2] = BEQ_I;
        do_reset();
        rs_data = 64'd7;
        rt_data = 64'd7;
        step(); step(); step();
        checks++; if (id_inst32 !== BEQ_I || bus32.addr !== 32'hC) begin failures++; $display("FAIL beq_in_id got=%h/%h exp=%h/c", id_inst32, bus32.addr, BEQ_I); end
        step();
        checks++; if (bus32.addr !== 32'h18) begin failures++; $display("FAIL beq_target got=%h exp=18", bus32.addr); end
        checks++; if (valid32 !== 1'b0) begin failures++; $display("FAIL beq_bubble got=%b exp=0", valid32); end
        checks++; if (ctrl32 !== 11'd0) begin failures++; $display("FAIL beq_ctrl got=%h exp=0", ctrl32); end
        checks++; if (fcnt32 !== 16'd1) begin failures++; $display("FAIL beq_flush_cnt got=%0d exp=1", fcnt32); end
        step();
        checks++; if (pc4_32 !== 32'h1C || id_inst32 !== mem32[6]) begin failures++; $display("FAIL beq_target_in_id got=%h/%h exp=1c/%h", pc4_32, id_inst32, mem32[6]); end
        $display("beq taken: pc=%h flush_cnt=%0d", bus32.addr, fcnt32);
    endtask

    task automatic test_bne_not_taken();
        fill_mem();
        mem32[2] = BNE_I;
        do_reset();
        rs_data = 64'd9;
        rt_data = 64'd9;
        step(); step(); step();
        step();
        checks++; if (bus32.addr !== 32'h10) begin failures++; $display("FAIL bne_pc got=%h exp=10", bus32.addr); end
        checks++; if (valid32 !== 1'b1 || fcnt32 !== 16'd0) begin failures++; $display("FAIL bne_flow got=%b/%0d exp=1/0", valid32, fcnt32); end
        $display("bne not taken: pc=%h valid=%b", bus32.addr, valid32);
    endtask

    task automatic test_load_use();
        fill_mem();
        mem32[0] = mk_add(5'd5, 5'd7);
        do_reset();
        step();
        idex_mem_read = 1'b1;
        idex_rt       = 5'd5;
        #1;
        checks++; if (ctrl32 !== 11'd0) begin failures++; $display("FAIL lu_ctrl got=%h exp=0", ctrl32); end
        step();
        checks++; if (bus32.addr !== 32'd4 || id_inst32 !== mem32[0]) begin failures++; $display("FAIL lu_hold got=%h/%h exp=4/%h", bus32.addr, id_inst32, mem32[0]); end
        checks++; if (scnt32 !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", scnt32); end
        idex_rt = 5'd0;
        #1;
        checks++; if (ctrl32 !== CTRL_VAL) begin failures++; $display("FAIL lu_r0_ctrl got=%h exp=%h", ctrl32, CTRL_VAL); end
        step();
        checks++; if (bus32.addr !== 32'd8 || scnt32 !== 16'd1) begin failures++; $display("FAIL lu_r0_flow got=%h/%0d exp=8/1", bus32.addr, scnt32); end
        $display("load-use: stall_cnt=%0d pc=%h", scnt32, bus32.addr);
    endtask

    task automatic test_branch_hazard();
        fill_mem();
        mem32[2] = BEQ_I;
        do_reset();
        rs_data = 64'd3;
        rt_data = 64'd3;
        step(); step(); step();
        // ALU producer of $2 in EX
        idex_reg_write = 1'b1;
        idex_rd        = 5'd2;
        #1;
        checks++; if (ctrl32 !== 11'd0) begin failures++; $display("FAIL bh_ctrl got=%h exp=0", ctrl32); end
        step();
        checks++; if (bus32.addr !== 32'hC || scnt32 !== 16'd1 || fcnt32 !== 16'd0) begin failures++; $display("FAIL bh_alu got=%h/%0d/%0d exp=c/1/0", bus32.addr, scnt32, fcnt32); end
        // Load producer of $1 now in MEM: one more stall
        idex_reg_write = 1'b0;
        exmem_mem_read = 1'b1;
        exmem_rd       = 5'd1;
        step();
        checks++; if (bus32.addr !== 32'hC || scnt32 !== 16'd2) begin failures++; $display("FAIL bh_load got=%h/%0d exp=c/2", bus32.addr, scnt32); end
        exmem_mem_read = 1'b0;
        step();
        checks++; if (bus32.addr !== 32'h18 || fcnt32 !== 16'd1) begin failures++; $display("FAIL bh_resolve got=%h/%0d exp=18/1", bus32.addr, fcnt32); end
        $display("branch hazard: stall_cnt=%0d pc=%h", scnt32, bus32.addr);
    endtask

    task automatic test_mem_wait();
        fill_mem();
        do_reset();
        step();
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus32.addr !== 32'd4 || valid32 !== 1'b0) begin failures++; $display("FAIL wait%0d got=%h/%b exp=4/0", k, bus32.addr, valid32); end
        end
        ready = 1'b1;
        step();
        checks++; if (valid32 !== 1'b1 || pc4_32 !== 32'd8 || id_inst32 !== mem32[1]) begin failures++; $display("FAIL wait_resume got=%b/%h/%h exp=1/8/%h", valid32, pc4_32, id_inst32, mem32[1]); end
        $display("mem wait: pc=%h valid=%b", bus32.addr, valid32);
    endtask

    task automatic test_ext_flush();
        fill_mem();
        mem32[0] = mk_add(5'd5, 5'd7);
        do_reset();
        step();
        idex_mem_read = 1'b1;
        idex_rt       = 5'd5;
        ext_flush     = 1'b1;
        step();
        checks++; if (valid32 !== 1'b1 || bus32.addr !== 32'd4 || fcnt32 !== 16'd0 || scnt32 !== 16'd1) begin failures++; $display("FAIL flush_in_stall got=%b/%h/%0d/%0d exp=1/4/0/1", valid32, bus32.addr, fcnt32, scnt32); end
        idex_mem_read = 1'b0;
        step();
        checks++; if (valid32 !== 1'b0 || id_inst32 !== 32'd0 || bus32.addr !== 32'd8 || fcnt32 !== 16'd1) begin failures++; $display("FAIL flush got=%b/%h/%h/%0d exp=0/0/8/1", valid32, id_inst32, bus32.addr, fcnt32); end
        ready = 1'b0;
        step();
        checks++; if (bus32.addr !== 32'd8 || fcnt32 !== 16'd2) begin failures++; $display("FAIL flush_noready got=%h/%0d exp=8/2", bus32.addr, fcnt32); end
        $display("ext flush: pc=%h flush_cnt=%0d", bus32.addr, fcnt32);
    endtask

    task automatic test_taken_not_ready();
        fill_mem();
        mem32[2] = BEQ_I;
        do_reset();
        rs_data = 64'd1;
        rt_data = 64'd1;
        step(); step(); step();
        ready = 1'b0;
        step();
        checks++; if (bus32.addr !== 32'h18 || valid32 !== 1'b0 || fcnt32 !== 16'd1) begin failures++; $display("FAIL taken_noready got=%h/%b/%0d exp=18/0/1", bus32.addr, valid32, fcnt32); end
        $display("taken w/o ready: pc=%h", bus32.addr);
    endtask

    task automatic test_jump64_saturation_reset();
        fill_mem();
        mem64[3] = J_I;
        mem64[0] = mk_add(5'd5, 5'd7);
        do_reset();
        #1;
        checks++; if (bus64.addr !== RST_PC64) begin failures++; $display("FAIL j64_first_fetch got=%h exp=%h", bus64.addr, RST_PC64); end
        step();
        checks++; if (pc4_64 !== 64'h0000_0001_4000_0010 || id_inst64 !== J_I) begin failures++; $display("FAIL j64_in_id got=%h/%h exp=0000000140000010/%h", pc4_64, id_inst64, J_I); end
        step();
        checks++; if (bus64.addr !== 64'h0000_0001_4000_0400 || fcnt64 !== 2'd1) begin failures++; $display("FAIL j64_target got=%h/%0d exp=0000000140000400/1", bus64.addr, fcnt64); end
        step();
        idex_mem_read = 1'b1;
        idex_rt       = 5'd5;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++; if (scnt64 !== 2'((k > 3) ? 3 : k)) begin failures++; $display("FAIL sat%0d got=%0d exp=%0d", k, scnt64, (k > 3) ? 3 : k); end
        end
        checks++; if (bus64.addr !== 64'h0000_0001_4000_0404) begin failures++; $display("FAIL sat_pc_hold got=%h exp=0000000140000404", bus64.addr); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus64.addr !== RST_PC64 || valid64 !== 1'b0 || id_inst64 !== 32'd0 || pc4_64 !== 64'd0) begin failures++; $display("FAIL async_rst_state got=%h/%b/%h/%h", bus64.addr, valid64, id_inst64, pc4_64); end
        checks++; if (scnt64 !== 2'd0 || fcnt64 !== 2'd0 || ctrl64 !== 11'd0) begin failures++; $display("FAIL async_rst_out got=%0d/%0d/%h exp=0/0/0", scnt64, fcnt64, ctrl64); end
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        step();
        checks++; if (pc4_64 !== RST_PC64 + 64'd4 || id_inst64 !== J_I) begin failures++; $display("FAIL post_rst_fetch got=%h/%h exp=%h/%h", pc4_64, id_inst64, RST_PC64 + 64'd4, J_I); end
        $display("jump64/sat/reset: stall_cnt=%0d pc4=%h", scnt64, pc4_64);
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_straight_line();
        test_beq_taken();
        test_bne_not_taken();
        test_load_use();
        test_branch_hazard();
        test_mem_wait();
        test_ext_flush();
        test_taken_not_ready();
        test_jump64_saturation_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
